// File: rtl/ps2_tx_pkg.sv
// ps2_tx_pkg
// Shared definitions for the PS/2 host-to-device transmitter.
//   - Default timing constants. The receiver and the controller use them too.
//   - Transmitter state encoding.
//   - Frame builder: {stop, odd parity, data[7:0]}.
package ps2_tx_pkg;

  // Default timing, derived from the system clock frequency.
  localparam int unsigned PS2_SYS_CLK_HZ     = 50_000_000;
  localparam int unsigned PS2_INHIBIT_US     = 100;
  localparam int unsigned PS2_TIMEOUT_US     = 15_000;
  localparam int unsigned PS2_INHIBIT_CYCLES = (PS2_SYS_CLK_HZ / 1_000_000) * PS2_INHIBIT_US;
  localparam int unsigned PS2_TIMEOUT_CYCLES = (PS2_SYS_CLK_HZ / 1_000_000) * PS2_TIMEOUT_US;

  localparam int unsigned PS2_FRAME_BITS = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_SHIFT,
    ST_ACK,
    ST_WAIT_IDLE
  } tx_state_e;

  // Bit 0 goes out first. The frame is data LSB first, then odd parity, then stop.
  function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge
// Two-flop synchronizers for the raw PS/2 clock and data lines. Also detects
// the falling edge of the synchronized clock. The receiver reuses this block.
// Ports:
//   clk_i, rst_i     system clock and asynchronous active-high reset
//   ps2_clk_i        raw PS/2 clock line (asynchronous)
//   ps2_din_i        raw PS/2 data line (asynchronous)
//   clk_sync_o       synchronized PS/2 clock
//   din_sync_o       synchronized PS/2 data
//   clk_fall_o       high for one cycle: synced clock was 1 and is now 0
module ps2_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ps2_clk_i,
  input  logic ps2_din_i,
  output logic clk_sync_o,
  output logic din_sync_o,
  output logic clk_fall_o
);

  logic [1:0] clk_ff_q, clk_ff_d;
  logic [1:0] din_ff_q, din_ff_d;
  logic       clk_prev_q, clk_prev_d;

  always_comb begin
    clk_ff_d   = {clk_ff_q[0], ps2_clk_i};
    din_ff_d   = {din_ff_q[0], ps2_din_i};
    clk_prev_d = clk_ff_q[1];
  end

  // Reset to the idle (released, pulled-up) level. This stops a spurious
  // falling edge from appearing right after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_ff_q   <= 2'b11;
      din_ff_q   <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      clk_ff_q   <= clk_ff_d;
      din_ff_q   <= din_ff_d;
      clk_prev_q <= clk_prev_d;
    end
  end

  assign clk_sync_o = clk_ff_q[1];
  assign din_sync_o = din_ff_q[1];
  assign clk_fall_o = clk_prev_q & ~clk_ff_q[1];

endmodule

// File: rtl/ps2_tx.sv
// ps2_tx
// Host-to-device PS/2 transmitter. It sends one command byte per strobe:
//   1. Inhibit: hold the clock low.
//   2. Request-to-send: data low, then release the clock.
//   3. Shift out data, parity and stop on the falling edges of the device clock.
//   4. Check the device acknowledge bit.
// Parameters:
//   INHIBIT_CYCLES  cycles the clock is held low before release (>= 1)
//   TIMEOUT_CYCLES  cycles from clock release to the forced error (>= 2)
// Ports:
//   clk_i, rst_i                system clock and asynchronous active-high reset
//   ps2_clk_i, ps2_din_i        raw open-drain PS/2 lines
//   ps2_clk_oe_o, ps2_din_oe_o  1 = pull the line low
//   tx_stb_i, tx_data_i         one-cycle send request and command byte
//   tx_busy_o                   transmission in flight
//   tx_done_o, tx_err_o         one-cycle completion strobes (ACK / NAK or timeout)
module ps2_tx
  import ps2_tx_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_din_i,
  output logic       ps2_clk_oe_o,
  output logic       ps2_din_oe_o,
  input  logic       tx_stb_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_busy_o,
  output logic       tx_done_o,
  output logic       tx_err_o
);

  localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  logic clk_sync, din_sync, clk_fall;

  ps2_sync_edge u_sync (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_din_i  (ps2_din_i),
    .clk_sync_o (clk_sync),
    .din_sync_o (din_sync),
    .clk_fall_o (clk_fall)
  );

  tx_state_e                 state_q, state_d;
  logic [PS2_FRAME_BITS-1:0] shift_q, shift_d;
  logic [INH_W-1:0]          inh_cnt_q, inh_cnt_d;
  logic [TO_W-1:0]           to_cnt_q, to_cnt_d;
  logic [3:0]                edge_cnt_q, edge_cnt_d;
  logic                      clk_oe_q, clk_oe_d;
  logic                      din_oe_q, din_oe_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    inh_cnt_d  = inh_cnt_q;
    to_cnt_d   = to_cnt_q;
    edge_cnt_d = edge_cnt_q;
    clk_oe_d   = clk_oe_q;
    din_oe_d   = din_oe_q;
    // Busy stays high on the cycle the state returns to IDLE.
    // It falls on the cycle after that.
    busy_d     = (state_q != ST_IDLE);
    done_d     = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        clk_oe_d = 1'b0;
        din_oe_d = 1'b0;
        if (tx_stb_i) begin
          shift_d   = ps2_frame(tx_data_i);
          // The counter holds the number of cycles the clock has been low,
          // counting the cycle being registered now.
          inh_cnt_d = INH_W'(1);
          clk_oe_d  = 1'b1;
          // The start bit goes low one cycle before the clock is released.
          // With a one-cycle inhibit, that cycle is the first one.
          din_oe_d  = (INHIBIT_CYCLES == 1);
          busy_d    = 1'b1;
          state_d   = ST_INHIBIT;
        end
      end

      ST_INHIBIT: begin
        inh_cnt_d = inh_cnt_q + INH_W'(1);
        if (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 1)) begin
          din_oe_d = 1'b1;
        end
        if (inh_cnt_q == INH_W'(INHIBIT_CYCLES)) begin
          clk_oe_d = 1'b0;
          din_oe_d = 1'b1;
          state_d  = ST_RTS;
        end
      end

      ST_RTS: begin
        // The clock was released on entry to this state, so this cycle is the
        // first one after release. Start the count at 1: the error strobe then
        // lands exactly TIMEOUT_CYCLES cycles after release.
        to_cnt_d   = TO_W'(1);
        edge_cnt_d = 4'd0;
        state_d    = ST_SHIFT;
      end

      ST_SHIFT: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (clk_fall) begin
          din_oe_d   = ~shift_q[0];
          shift_d    = {1'b0, shift_q[PS2_FRAME_BITS-1:1]};
          edge_cnt_d = edge_cnt_q + 4'd1;
          if (edge_cnt_q == 4'd9) begin
            state_d = ST_ACK;
          end
        end
      end

      ST_ACK: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (clk_fall) begin
          edge_cnt_d = edge_cnt_q + 4'd1;
          if (!din_sync) begin
            state_d = ST_WAIT_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end

      ST_WAIT_IDLE: begin
        if (clk_sync && din_sync) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Timeout overrides any edge that lands on the same cycle.
    if (((state_q == ST_SHIFT) || (state_q == ST_ACK)) &&
        (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1))) begin
      clk_oe_d = 1'b0;
      din_oe_d = 1'b0;
      done_d   = 1'b0;
      err_d    = 1'b1;
      state_d  = ST_IDLE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      inh_cnt_q  <= '0;
      to_cnt_q   <= '0;
      edge_cnt_q <= '0;
      clk_oe_q   <= 1'b0;
      din_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      inh_cnt_q  <= inh_cnt_d;
      to_cnt_q   <= to_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      clk_oe_q   <= clk_oe_d;
      din_oe_q   <= din_oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign ps2_clk_oe_o = clk_oe_q;
  assign ps2_din_oe_o = din_oe_q;
  assign tx_busy_o    = busy_q;
  assign tx_done_o    = done_q;
  assign tx_err_o     = err_q;

endmodule

// File: tb/tb_ps2_tx.sv
// tb_ps2_tx
// Drives ps2_tx against a behavioural PS/2 device model on a shared
// open-drain bus. Expected outcomes and frames go into a scoreboard queue when
// each command is issued. A monitor pops and compares them whenever the DUT
// strobes done or err.
module tb_ps2_tx;

  localparam int INH = 20;    // scaled-down inhibit
  localparam int TO  = 2000;  // scaled-down timeout
  localparam int H   = 20;    // device half clock period, in system clocks

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_stb = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       clk_oe, din_oe, tx_busy, tx_done, tx_err;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clk_line, ps2_din_line;

  // Open-drain wired-AND of host and device.
  assign ps2_clk_line = ~(clk_oe | dev_clk_low);
  assign ps2_din_line = ~(din_oe | dev_data_low);

  ps2_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .ps2_clk_i    (ps2_clk_line),
    .ps2_din_i    (ps2_din_line),
    .ps2_clk_oe_o (clk_oe),
    .ps2_din_oe_o (din_oe),
    .tx_stb_i     (tx_stb),
    .tx_data_i    (tx_data),
    .tx_busy_o    (tx_busy),
    .tx_done_o    (tx_done),
    .tx_err_o     (tx_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: what the device should see on the data line for edges 1..10.
  function automatic logic [9:0] ref_frame(input logic [7:0] d);
    logic [9:0] f;
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      f[i] = d[i];
      ones += int'(d[i]);
    end
    f[8] = ((ones % 2) == 0);  // total count of ones including parity is odd
    f[9] = 1'b1;               // stop: line released
    return f;
  endfunction

  typedef struct {
    bit         is_err;
    bit         check_bits;
    logic [9:0] bits;
  } exp_t;

  exp_t       exp_q[$];
  logic [9:0] got_q[$];
  int         n_out = 0;
  int         last_out_cyc = 0;
  int         rel_cyc = 0;

  // Scoreboard monitor.
  exp_t e;
  logic [9:0] g;
  bit chk_busy_next = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (chk_busy_next) begin
        check("busy_fall", tx_busy, 1'b0);
        chk_busy_next = 0;
      end
      if (tx_done || tx_err) begin
        n_out++;
        last_out_cyc = cyc;
        check("done_err_exclusive", tx_done & tx_err, 1'b0);
        check("lines_released", {clk_oe, din_oe}, 2'b00);
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_strobe: got done=%0d err=%0d, expected none", tx_done, tx_err);
        end else begin
          e = exp_q.pop_front();
          check("outcome_done", tx_done, !e.is_err);
          if (e.check_bits) begin
            if (got_q.size() == 0) begin
              n_chk++;
              n_fail++;
              $display("FAIL frame_missing: got no frame, expected 0x%0h", e.bits);
            end else begin
              g = got_q.pop_front();
              check("frame_bits", g, e.bits);
            end
          end
        end
        chk_busy_next = 1;
      end
    end
  end

  // Inhibit length and data lead at clock release.
  bit prev_clk_oe = 0;
  int clk_run = 0;
  int din_run = 0;
  always @(negedge clk) begin
    if (rst) begin
      prev_clk_oe = 0;
      clk_run = 0;
      din_run = 0;
    end else begin
      if (prev_clk_oe && !clk_oe) begin
        check("inhibit_len", clk_run, INH);
        check("data_lead", din_run, 1);
        rel_cyc = cyc;
      end
      clk_run = clk_oe ? clk_run + 1 : 0;
      din_run = din_oe ? din_run + 1 : 0;
      prev_clk_oe = clk_oe;
    end
  end

  task automatic expect_frame(input logic [7:0] d, input bit ack);
    exp_t x;
    x.is_err = !ack;
    x.check_bits = 1;
    x.bits = ref_frame(d);
    exp_q.push_back(x);
  endtask

  task automatic issue(input logic [7:0] d);
    @(negedge clk);
    tx_data = d;
    tx_stb = 1'b1;
    @(negedge clk);
    tx_stb = 1'b0;
    check("stb_to_clk_oe", clk_oe, 1'b1);
    check("busy_after_stb", tx_busy, 1'b1);
  endtask

  // Device: wait for request-to-send, then generate the clock edges.
  task automatic run_device(input int edges, input bit ack);
    logic [9:0] bits;
    bit seen;
    bits = '0;
    seen = 0;
    for (int i = 0; i < INH + 50; i++) begin
      @(posedge clk);
      if (ps2_clk_line && !ps2_din_line) begin
        seen = 1;
        break;
      end
    end
    check("rts_seen", seen, 1'b1);
    if (!seen) return;
    repeat (H) @(posedge clk);
    for (int ed = 1; ed <= edges; ed++) begin
      if (ed == 11 && ack) begin
        dev_data_low = 1'b1;
        repeat (5) @(posedge clk);
      end
      dev_clk_low = 1'b1;
      repeat (H) @(posedge clk);
      if (ed <= 10) bits[ed-1] = ps2_din_line;
      dev_clk_low = 1'b0;
      repeat (H) @(posedge clk);
      if (ed == 10) got_q.push_back(bits);
      if (ed == 11) dev_data_low = 1'b0;
    end
  endtask

  task automatic wait_outcomes(input int target, input string name);
    int k;
    k = 0;
    while (n_out < target && k < 4 * TO) begin
      @(negedge clk);
      k++;
    end
    check(name, n_out, target);
    repeat (4) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input bit ack);
    int tgt;
    tgt = n_out + 1;
    $display("tx 0x%02h ack=%0d", d, ack);
    expect_frame(d, ack);
    issue(d);
    run_device(11, ack);
    wait_outcomes(tgt, "outcome_seen");
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int tgt;
    exp_t x;
    logic [7:0] d;
    bit a;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_clk_oe", clk_oe, 1'b0);
    check("rst_din_oe", din_oe, 1'b0);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_done", tx_done, 1'b0);
    check("rst_err", tx_err, 1'b0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    send(8'hED, 1'b1);
    send(8'hF4, 1'b1);
    send(8'h3C, 1'b0);  // NAK

    // Device never clocks: error exactly TO cycles after release.
    $display("tx 0x55 timeout");
    x.is_err = 1;
    x.check_bits = 0;
    x.bits = '0;
    exp_q.push_back(x);
    tgt = n_out + 1;
    issue(8'h55);
    wait_outcomes(tgt, "timeout_seen");
    check("timeout_cycles", last_out_cyc - rel_cyc, TO);

    // Second strobe during a send is ignored.
    $display("tx 0xFF with ignored 0x00 strobe");
    expect_frame(8'hFF, 1'b1);
    tgt = n_out + 1;
    issue(8'hFF);
    repeat (5) @(negedge clk);
    tx_data = 8'h00;
    tx_stb = 1'b1;
    @(negedge clk);
    tx_stb = 1'b0;
    run_device(11, 1'b1);
    wait_outcomes(tgt, "ignored_stb_seen");
    check("queue_empty", exp_q.size(), 0);

    // Reset after edge 4.
    $display("tx 0xFF reset after edge 4");
    issue(8'hFF);
    run_device(4, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("midrst_clk_oe", clk_oe, 1'b0);
    check("midrst_din_oe", din_oe, 1'b0);
    check("midrst_busy", tx_busy, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    send(8'hFF, 1'b1);

    // Randomized commands.
    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom_range(0, 255));
      a = ($urandom_range(0, 3) != 0);
      send(d, a);
    end

    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
